hazard_fwd_unit: RTL and testbench

- Scoreboard-based hazard detection and forwarding controller for the 5-stage 32-bit MIPS pipeline (IF/ID/EX/MEM/WB).
- Shadows the datapath pipeline registers with its own EX/MEM/WB entries (valid, write-enable, dest, is_load, sources).
- Drives operand-forward selects for the ALU inputs, load-use stalls of PC and IF/ID, and flushes on taken branch/jump.
- Generalises the unprotected pipeline: register-address width and branch-shadow depth are parametrised.

---
 rtl/hazard_fwd_unit.sv | 229 ++++++++++++++++++++++
 tb/tb_hazard_fwd_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit
//   Hazard detection and forwarding controller for the 5-stage MIPS pipeline.
//   Keeps shadow EX/MEM/WB scoreboard entries alongside the datapath pipeline
//   registers and derives, combinationally from them and the ID instruction:
//     - ALU operand forward selects (00 regfile, 01 MEM ALU result, 10 WB data)
//     - a one-cycle load-use stall of PC and IF/ID with a bubble into ID/EX
//     - squash of younger instructions on a taken branch/jump resolved in EX
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   id_*              decoded ID instruction (valid, sources, use flags,
//                     write enable, destination, load flag)
//   ex_redirect       taken branch/jump in EX this cycle
//   stall, ex_bubble  hold PC/IF-ID, load NOP into ID/EX
//   flush             squash IF/ID (plus ID/EX when BR_FLUSH = 2)
//   fwd_a, fwd_b      ALU operand forward selects
//   stall_cnt         load-use stall cycles (HAZARD_PERF_EN builds only)
//   flush_cnt         redirects taken       (HAZARD_PERF_EN builds only)
//
// Build option
//   HAZARD_PERF_EN    define to build the saturating performance counters;
//                     otherwise both counter ports are tied to zero.

module hazard_fwd_unit #(
   parameter int unsigned DIR_SIZE_INTERNAL = 5,
   parameter int unsigned BR_FLUSH          = 2,
   parameter int unsigned CNT_WIDTH         = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         id_valid,
   input  logic [DIR_SIZE_INTERNAL-1:0] id_rs,
   input  logic [DIR_SIZE_INTERNAL-1:0] id_rt,
   input  logic                         id_use_rs,
   input  logic                         id_use_rt,
   input  logic                         id_wr_en,
   input  logic [DIR_SIZE_INTERNAL-1:0] id_dest,
   input  logic                         id_is_load,
   input  logic                         ex_redirect,
   output logic                         stall,
   output logic                         ex_bubble,
   output logic                         flush,
   output logic [1:0]                   fwd_a,
   output logic [1:0]                   fwd_b,
   output logic [CNT_WIDTH-1:0]         stall_cnt,
   output logic [CNT_WIDTH-1:0]         flush_cnt
);

   localparam logic [1:0] ST_RUN      = 2'd0;
   localparam logic [1:0] ST_LU_STALL = 2'd1;
   localparam logic [1:0] ST_FLUSH    = 2'd2;

   // With a single-slot branch shadow the instruction in ID survives the
   // redirect (delay slot); with two slots it is squashed too.
   localparam logic SQUASH_ID = (BR_FLUSH >= 2);

   logic [1:0] state_q, state_d;

   // EX entry
   logic                         ex_valid_q, ex_valid_d;
   logic                         ex_wr_en_q, ex_wr_en_d;
   logic                         ex_is_load_q, ex_is_load_d;
   logic                         ex_use_rs_q, ex_use_rs_d;
   logic                         ex_use_rt_q, ex_use_rt_d;
   logic [DIR_SIZE_INTERNAL-1:0] ex_dest_q, ex_dest_d;
   logic [DIR_SIZE_INTERNAL-1:0] ex_rs_q, ex_rs_d;
   logic [DIR_SIZE_INTERNAL-1:0] ex_rt_q, ex_rt_d;
   // MEM entry
   logic                         mem_valid_q, mem_valid_d;
   logic                         mem_wr_en_q, mem_wr_en_d;
   logic                         mem_is_load_q, mem_is_load_d;
   logic [DIR_SIZE_INTERNAL-1:0] mem_dest_q, mem_dest_d;
   // WB entry
   logic                         wb_valid_q, wb_valid_d;
   logic                         wb_wr_en_q, wb_wr_en_d;
   logic [DIR_SIZE_INTERNAL-1:0] wb_dest_q, wb_dest_d;

   logic load_use, in_flush, flush_int, stall_int, squash_id, ex_take;
   logic mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;
   logic load_fwd_hazard;

   always_comb begin
      load_use  = id_valid && ex_valid_q && ex_is_load_q && (ex_dest_q != '0) &&
                  ((id_use_rs && (id_rs == ex_dest_q)) ||
                   (id_use_rt && (id_rt == ex_dest_q)));
      in_flush  = (state_q == ST_FLUSH);
      // Redirect outranks load-use: the stalled consumer is being squashed.
      flush_int = !rst && (ex_redirect || in_flush);
      stall_int = !rst && load_use && !flush_int;
      squash_id = (ex_redirect && SQUASH_ID) || in_flush;
      ex_take   = id_valid && !stall_int && !squash_id;
   end

   assign stall     = stall_int;
   assign ex_bubble = stall_int;
   assign flush     = flush_int;

   // FLUSH only covers the extra shadow cycle, so with BR_FLUSH = 1 a
   // redirect returns straight to RUN.
   always_comb begin
      state_d = ST_RUN;
      if (ex_redirect)
         state_d = SQUASH_ID ? ST_FLUSH : ST_RUN;
      else if ((state_q == ST_RUN) && load_use)
         state_d = ST_LU_STALL;
   end

   always_comb begin
      ex_valid_d   = ex_take;
      ex_wr_en_d   = id_wr_en;
      ex_is_load_d = id_is_load;
      ex_use_rs_d  = id_use_rs;
      ex_use_rt_d  = id_use_rt;
      ex_dest_d    = id_dest;
      ex_rs_d      = id_rs;
      ex_rt_d      = id_rt;

      mem_valid_d   = ex_valid_q;
      mem_wr_en_d   = ex_wr_en_q;
      mem_is_load_d = ex_is_load_q;
      mem_dest_d    = ex_dest_q;

      wb_valid_d = mem_valid_q;
      wb_wr_en_d = mem_wr_en_q;
      wb_dest_d  = mem_dest_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_RUN;
         ex_valid_q    <= 1'b0;
         ex_wr_en_q    <= 1'b0;
         ex_is_load_q  <= 1'b0;
         ex_use_rs_q   <= 1'b0;
         ex_use_rt_q   <= 1'b0;
         ex_dest_q     <= '0;
         ex_rs_q       <= '0;
         ex_rt_q       <= '0;
         mem_valid_q   <= 1'b0;
         mem_wr_en_q   <= 1'b0;
         mem_is_load_q <= 1'b0;
         mem_dest_q    <= '0;
         wb_valid_q    <= 1'b0;
         wb_wr_en_q    <= 1'b0;
         wb_dest_q     <= '0;
      end else begin
         state_q       <= state_d;
         ex_valid_q    <= ex_valid_d;
         ex_wr_en_q    <= ex_wr_en_d;
         ex_is_load_q  <= ex_is_load_d;
         ex_use_rs_q   <= ex_use_rs_d;
         ex_use_rt_q   <= ex_use_rt_d;
         ex_dest_q     <= ex_dest_d;
         ex_rs_q       <= ex_rs_d;
         ex_rt_q       <= ex_rt_d;
         mem_valid_q   <= mem_valid_d;
         mem_wr_en_q   <= mem_wr_en_d;
         mem_is_load_q <= mem_is_load_d;
         mem_dest_q    <= mem_dest_d;
         wb_valid_q    <= wb_valid_d;
         wb_wr_en_q    <= wb_wr_en_d;
         wb_dest_q     <= wb_dest_d;
      end
   end

   // Forwarding: register 0 never matches; MEM outranks WB (newest value).
   always_comb begin
      mem_hit_a = mem_valid_q && mem_wr_en_q && (mem_dest_q != '0) && (mem_dest_q == ex_rs_q);
      mem_hit_b = mem_valid_q && mem_wr_en_q && (mem_dest_q != '0) && (mem_dest_q == ex_rt_q);
      wb_hit_a  = wb_valid_q && wb_wr_en_q && (wb_dest_q != '0) && (wb_dest_q == ex_rs_q);
      wb_hit_b  = wb_valid_q && wb_wr_en_q && (wb_dest_q != '0) && (wb_dest_q == ex_rt_q);

      fwd_a = 2'b00;
      if (!rst && ex_valid_q && ex_use_rs_q) begin
         if (mem_hit_a && !mem_is_load_q) fwd_a = 2'b01;
         else if (wb_hit_a)               fwd_a = 2'b10;
      end
      fwd_b = 2'b00;
      if (!rst && ex_valid_q && ex_use_rt_q) begin
         if (mem_hit_b && !mem_is_load_q) fwd_b = 2'b01;
         else if (wb_hit_b)               fwd_b = 2'b10;
      end

      // A load still in MEM cannot supply data; the load-use stall keeps
      // its consumer out of EX, so this should never be seen.
      load_fwd_hazard = ex_valid_q && mem_is_load_q &&
                        ((ex_use_rs_q && mem_hit_a) || (ex_use_rt_q && mem_hit_b));
   end

`ifndef SYNTHESIS
   assert property (@(posedge clk) disable iff (rst) !load_fwd_hazard);
`endif

`ifdef HAZARD_PERF_EN
   logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
   logic                 flush_prev_q, flush_prev_d;

   // Counters saturate at all-ones; flush_cnt counts rising edges of flush.
   always_comb begin
      stall_cnt_d  = stall_cnt_q;
      flush_cnt_d  = flush_cnt_q;
      flush_prev_d = flush_int;
      if (stall_int && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
      if (flush_int && !flush_prev_q && (flush_cnt_q != '1))
         flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q  <= '0;
         flush_cnt_q  <= '0;
         flush_prev_q <= 1'b0;
      end else begin
         stall_cnt_q  <= stall_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
         flush_prev_q <= flush_prev_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit: directed pipeline scenarios followed by random
// instruction streams, checked against a stage-array model of the pipeline.
module tb_hazard_fwd_unit;

   localparam int unsigned W  = 5;
   localparam int unsigned CW = 16;
   localparam int unsigned BR = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst = 1'b1;
   logic          id_valid = 1'b0, id_use_rs = 1'b0, id_use_rt = 1'b0;
   logic          id_wr_en = 1'b0, id_is_load = 1'b0, ex_redirect = 1'b0;
   logic [W-1:0]  id_rs = '0, id_rt = '0, id_dest = '0;
   logic          stall, ex_bubble, flush;
   logic [1:0]    fwd_a, fwd_b;
   logic [CW-1:0] stall_cnt, flush_cnt;

   logic          stall1, ex_bubble1, flush1;
   logic [1:0]    fwd_a1, fwd_b1;
   logic [CW-1:0] stall_cnt1, flush_cnt1;

   hazard_fwd_unit #(.DIR_SIZE_INTERNAL(W), .BR_FLUSH(BR), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en),
      .id_dest(id_dest), .id_is_load(id_is_load), .ex_redirect(ex_redirect),
      .stall(stall), .ex_bubble(ex_bubble), .flush(flush), .fwd_a(fwd_a),
      .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

   // Single-slot branch shadow variant; only its flush timing is exercised.
   hazard_fwd_unit #(.DIR_SIZE_INTERNAL(W), .BR_FLUSH(1), .CNT_WIDTH(CW)) dut1 (
      .clk(clk), .rst(rst), .id_valid(1'b0), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en),
      .id_dest(id_dest), .id_is_load(id_is_load), .ex_redirect(ex_redirect),
      .stall(stall1), .ex_bubble(ex_bubble1), .flush(flush1), .fwd_a(fwd_a1),
      .fwd_b(fwd_b1), .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1));

   typedef struct {
      bit       v, urs, urt, we, ld;
      bit [4:0] rs, rt, d;
   } ent_t;

   // pipe[0] = EX, pipe[1] = MEM, pipe[2] = WB
   ent_t pipe[3];
   int   flush_left = 0;
   int   exp_stall_cnt = 0, exp_flush_cnt = 0;
   bit   prev_flush = 1'b0;
   bit   last_stall = 1'b0;
   int   checks = 0, errors = 0;

   function automatic ent_t mk(bit v, bit [4:0] rs, bit [4:0] rt, bit urs, bit urt,
                               bit we, bit [4:0] d, bit ld);
      ent_t e;
      e.v = v; e.rs = rs; e.rt = rt; e.urs = urs; e.urt = urt;
      e.we = we; e.d = d; e.ld = ld;
      return e;
   endfunction

   function automatic bit writes(ent_t e, bit [4:0] r);
      return e.v && e.we && (e.d != 0) && (e.d == r);
   endfunction

   function automatic bit [1:0] expect_sel(bit used, bit [4:0] r);
      if (!pipe[0].v || !used) return 2'b00;
      if (writes(pipe[1], r) && !pipe[1].ld) return 2'b01;
      if (writes(pipe[2], r)) return 2'b10;
      return 2'b00;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: drive at negedge, check outputs, advance the model.
   task automatic cyc(input ent_t ins, input bit redir, input bit r);
      bit lu, fl, st, squash;
      bit [1:0] ea, eb;
      @(negedge clk);
      rst = r; ex_redirect = redir;
      id_valid = ins.v; id_rs = ins.rs; id_rt = ins.rt; id_use_rs = ins.urs;
      id_use_rt = ins.urt; id_wr_en = ins.we; id_dest = ins.d; id_is_load = ins.ld;
      #1;
      lu = 0; fl = 0; st = 0; ea = 0; eb = 0;
      if (!r) begin
         lu = ins.v && pipe[0].v && pipe[0].ld && (pipe[0].d != 0) &&
              ((ins.urs && ins.rs == pipe[0].d) || (ins.urt && ins.rt == pipe[0].d));
         fl = redir || (flush_left > 0);
         st = lu && !fl;
         ea = expect_sel(pipe[0].urs, pipe[0].rs);
         eb = expect_sel(pipe[0].urt, pipe[0].rt);
      end
      chk("stall", stall, st);
      chk("ex_bubble", ex_bubble, st);
      chk("flush", flush, fl);
      chk("fwd_a", fwd_a, ea);
      chk("fwd_b", fwd_b, eb);
`ifdef HAZARD_PERF_EN
      chk("stall_cnt", stall_cnt, exp_stall_cnt);
      chk("flush_cnt", flush_cnt, exp_flush_cnt);
`else
      chk("stall_cnt", stall_cnt, 0);
      chk("flush_cnt", flush_cnt, 0);
`endif
      last_stall = st;
      if (r) begin
         for (int i = 0; i < 3; i++) pipe[i] = mk(0, 0, 0, 0, 0, 0, 0, 0);
         flush_left = 0; exp_stall_cnt = 0; exp_flush_cnt = 0; prev_flush = 0;
      end else begin
         if (st) exp_stall_cnt++;
         if (fl && !prev_flush) exp_flush_cnt++;
         prev_flush = fl;
         squash = (redir && BR >= 2) || (flush_left > 0);
         pipe[2] = pipe[1];
         pipe[1] = pipe[0];
         pipe[0] = (ins.v && !st && !squash) ? ins : mk(0, 0, 0, 0, 0, 0, 0, 0);
         flush_left = redir ? (BR - 1) : ((flush_left > 0) ? flush_left - 1 : 0);
      end
   endtask

   ent_t nop, ins;

   initial begin
      nop = mk(0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) pipe[i] = nop;

      // reset
      cyc(nop, 0, 1);
      cyc(nop, 0, 1);
      cyc(nop, 0, 0);
      chk("reset_flush1", flush1, 0);
      chk("reset_stall1", stall1, 0);
      chk("reset_bubble1", ex_bubble1, 0);
      chk("reset_fwd1", {fwd_a1, fwd_b1}, 0);
      chk("reset_cnt1", stall_cnt1, 0);

      // add r3<-r1,r2 ; sub r4<-r3,r5
      cyc(mk(1, 1, 2, 1, 1, 1, 3, 0), 0, 0);
      cyc(mk(1, 3, 5, 1, 1, 1, 4, 0), 0, 0);
      cyc(nop, 0, 0);
      chk("b2b_fwd_a", fwd_a, 2'b01);
      chk("b2b_fwd_b", fwd_b, 2'b00);
      chk("b2b_stall", stall, 0);
      repeat (3) cyc(nop, 0, 0);

      // add r3 ; nop ; or r6<-r1,r3
      cyc(mk(1, 1, 2, 1, 1, 1, 3, 0), 0, 0);
      cyc(nop, 0, 0);
      cyc(mk(1, 1, 3, 1, 1, 1, 6, 0), 0, 0);
      cyc(nop, 0, 0);
      chk("wb_fwd_a", fwd_a, 2'b00);
      chk("wb_fwd_b", fwd_b, 2'b10);
      repeat (3) cyc(nop, 0, 0);

      // lw r2 ; add r4<-r2,r2
      cyc(mk(1, 1, 0, 1, 0, 1, 2, 1), 0, 0);
      cyc(mk(1, 2, 2, 1, 1, 1, 4, 0), 0, 0);
      chk("lu_stall", stall, 1);
      chk("lu_bubble", ex_bubble, 1);
      cyc(mk(1, 2, 2, 1, 1, 1, 4, 0), 0, 0);
      chk("lu_stall_len", stall, 0);
      cyc(nop, 0, 0);
      chk("lu_fwd_a", fwd_a, 2'b10);
      chk("lu_fwd_b", fwd_b, 2'b10);
      repeat (3) cyc(nop, 0, 0);

      // writes to r0 never forward or stall
      cyc(mk(1, 1, 2, 1, 1, 1, 0, 0), 0, 0);
      cyc(mk(1, 0, 0, 1, 1, 1, 5, 0), 0, 0);
      cyc(nop, 0, 0);
      chk("r0_fwd_a", fwd_a, 2'b00);
      chk("r0_fwd_b", fwd_b, 2'b00);
      cyc(mk(1, 1, 0, 1, 0, 1, 0, 1), 0, 0);
      cyc(mk(1, 0, 0, 1, 1, 1, 5, 0), 0, 0);
      chk("r0_lu_stall", stall, 0);
      repeat (3) cyc(nop, 0, 0);

      // redirect in the same cycle as a load-use
      cyc(mk(1, 1, 0, 1, 0, 1, 2, 1), 0, 0);
      cyc(mk(1, 2, 2, 1, 1, 1, 4, 0), 1, 0);
      chk("br_flush", flush, 1);
      chk("br_stall", stall, 0);
      chk("br_bubble", ex_bubble, 0);
      chk("br1_flush", flush1, 1);
      cyc(nop, 0, 0);
      chk("br_flush_2nd", flush, 1);
      chk("br1_flush_len", flush1, 0);
      cyc(nop, 0, 0);
      chk("br_flush_end", flush, 0);
      chk("br_no_fwd", {fwd_a, fwd_b}, 0);
      repeat (3) cyc(nop, 0, 0);

      // reset while stalled on a load-use
      cyc(mk(1, 1, 0, 1, 0, 1, 2, 1), 0, 0);
      cyc(mk(1, 2, 2, 1, 1, 1, 4, 0), 0, 0);
      chk("rst_pre_stall", stall, 1);
      cyc(mk(1, 2, 2, 1, 1, 1, 4, 0), 0, 1);
      cyc(nop, 0, 0);
      chk("rst_outputs", {stall, ex_bubble, flush, fwd_a, fwd_b}, 0);

      // three load-use stalls after reset
      for (int k = 0; k < 3; k++) begin
         cyc(mk(1, 1, 0, 1, 0, 1, 7, 1), 0, 0);
         cyc(mk(1, 0, 7, 0, 1, 1, 6, 0), 0, 0);
         cyc(mk(1, 0, 7, 0, 1, 1, 6, 0), 0, 0);
      end
      cyc(nop, 0, 0);
`ifdef HAZARD_PERF_EN
      chk("perf_three_stalls", stall_cnt, 3);
`else
      chk("perf_tied_off", stall_cnt, 0);
`endif

      // random instruction stream; a stalled ID instruction is re-presented
      ins = nop;
      for (int n = 0; n < 600; n++) begin
         if (!last_stall)
            ins = mk(($urandom % 8) != 0, 5'($urandom % 8), 5'($urandom % 8),
                     1'($urandom % 2), 1'($urandom % 2), ($urandom % 4) != 0,
                     5'($urandom % 8), ($urandom % 3) == 0);
         cyc(ins, ($urandom % 10) == 0, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
